usb_axi_wr_bridge: RTL and testbench
====================================

USB_AXI_WR_BRIDGE -- requirements
Module: usb_axi_wr_bridge

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, number of buffered write entries (power of two, >=2).
REQ-002 SHALL have parameter ADDR_W, default 32, memory address width.
REQ-003 SHALL have parameter DATA_W, default 64, write data width.
REQ-004 SHALL have port axi_clk  input  1  the single clock; all logic is on its rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-006 SHALL have port bmem_wr_en  input  1  write request from the USB stage, held high until bmem_resp.
REQ-007 SHALL have port bmem_wr_addr  input  ADDR_W  byte address of the request.
REQ-008 SHALL have port bmem_wr_data  input  DATA_W  write payload.
REQ-009 SHALL have port bmem_resp  output  1  one-cycle acceptance pulse to the USB stage.
REQ-010 SHALL have ports m_axi_awaddr out ADDR_W, m_axi_awlen out 8, m_axi_awsize out 3, m_axi_awburst out 2, m_axi_awvalid out 1, m_axi_awready in 1: AXI4 write-address channel.
REQ-011 SHALL have ports m_axi_wdata out DATA_W, m_axi_wstrb out DATA_W/8, m_axi_wlast out 1, m_axi_wvalid out 1, m_axi_wready in 1: AXI4 write-data channel.
REQ-012 SHALL have ports m_axi_bresp in 2, m_axi_bvalid in 1, m_axi_bready out 1: AXI4 write-response channel.
REQ-013 SHALL have port wr_err_o  output  1  sticky flag, set on any non-OKAY bresp.
REQ-014 SHALL have port fifo_level_o  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Function
REQ-015 Request SHALL be accepted in a cycle where bmem_wr_en=1, FIFO not full and bmem_resp=0; addr and data are pushed.
REQ-016 bmem_resp SHALL be registered: high exactly the cycle after acceptance, for one cycle; no acceptance occurs while bmem_resp=1.
REQ-017 Pushed address SHALL have bits [2:0] forced to zero (8-byte aligned).
REQ-018 Constant outputs SHALL be: awlen=0, awsize=3'b011, awburst=2'b01 (INCR), wstrb all ones, wlast=1 whenever wvalid=1.
REQ-019 FSM states SHALL be IDLE, SEND, WAIT_B.
REQ-020 IDLE->SEND when FIFO non-empty; on entry awvalid and wvalid both rise next cycle, carrying the FIFO head.
REQ-021 In SEND, awvalid SHALL drop the cycle after its own awvalid&awready handshake and wvalid likewise, independently; AW and W handshakes may occur in either order or the same cycle.
REQ-022 SEND->WAIT_B once both handshakes have completed; awaddr/wdata SHALL stay stable while respective valid is high.
REQ-023 bready SHALL be 1 only in WAIT_B; on bvalid&bready the FIFO head SHALL pop and FSM goes to IDLE (or directly to SEND if another entry remains).
REQ-024 bresp!=2'b00 SHALL set wr_err_o (cleared only by rst); the entry is still popped, no retry.
REQ-025 Push and pop in the same cycle SHALL leave fifo_level_o unchanged; full FIFO SHALL stall acceptance with bmem_wr_en held.
REQ-026 FIFO pointers SHALL wrap modulo FIFO_DEPTH; at most one AXI write outstanding.

Reset
REQ-027 On rst, asynchronously: FSM=IDLE, FIFO empty, fifo_level_o=0, bmem_resp=0, awvalid=0, wvalid=0, bready=0, wr_err_o=0, awaddr=0, wdata=0.
REQ-028 Reset mid-transaction SHALL discard the in-flight and buffered entries; no AXI valid is reasserted until a new request.

Structure
REQ-029 Package usb_axi_pkg SHALL hold the FSM state enum and AXI constants (AXI_SIZE_8B, AXI_BURST_INCR, AXI_RESP_OKAY).
REQ-030 FIFO SHALL be sub-module usb_wr_fifo (push/pop/full/empty/level, async reset).

Verification
REQ-031 Single write addr 0x1000_0007, data 0xDEAD_BEEF_0123_4567, awready=wready=1, bvalid 2 cycles later -> awaddr 0x1000_0000, bmem_resp one cycle after accept, level returns 0.
REQ-032 awready delayed 5 cycles, wready immediate -> wvalid drops after 1 cycle, awvalid held stable 5 cycles, bready only after both.
REQ-033 awready=0 forever, 5 back-to-back requests with FIFO_DEPTH=4 -> 4 bmem_resp pulses, level=4, 5th held stalled.
REQ-034 bresp=2'b10 on one write -> wr_err_o=1 and stays 1 through subsequent OKAY writes.
REQ-035 rst asserted while in WAIT_B with level=3 -> all valids and level 0 immediately; next request behaves as REQ-031.

Source files
------------

// File: rtl/usb_axi_pkg.sv
// usb_axi_pkg: FSM states and AXI4 encodings shared by the USB-to-AXI write bridge
package usb_axi_pkg;
  typedef enum logic [1:0] {IDLE, SEND, WAIT_B} state_t;
  localparam logic [2:0] AXI_SIZE_8B = 3'b011;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY = 2'b00;
endpackage

// File: rtl/usb_wr_fifo.sv
// usb_wr_fifo: power-of-two FIFO with head and next-to-head read ports
module usb_wr_fifo #(
  parameter int DEPTH = 4,
  parameter int W = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             din,
  output logic [W-1:0]             dout,
  output logic [W-1:0]             dout_nxt,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  assign dout = mem[rd_ptr];
  assign dout_nxt = mem[rd_ptr + AW'(1)];
  assign full = level == (AW+1)'(DEPTH);
  assign empty = level == '0;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      level <= level + (AW+1)'(push) - (AW+1)'(pop);
    end
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= din;
endmodule

// File: rtl/usb_axi_wr_bridge.sv
// usb_axi_wr_bridge: buffers USB write requests and issues them as single-beat AXI4 writes,
// one outstanding at a time.
module usb_axi_wr_bridge
  import usb_axi_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64
) (
  input  logic                          axi_clk,
  input  logic                          rst,
  input  logic                          bmem_wr_en,
  input  logic [ADDR_W-1:0]             bmem_wr_addr,
  input  logic [DATA_W-1:0]             bmem_wr_data,
  output logic                          bmem_resp,
  output logic [ADDR_W-1:0]             m_axi_awaddr,
  output logic [7:0]                    m_axi_awlen,
  output logic [2:0]                    m_axi_awsize,
  output logic [1:0]                    m_axi_awburst,
  output logic                          m_axi_awvalid,
  input  logic                          m_axi_awready,
  output logic [DATA_W-1:0]             m_axi_wdata,
  output logic [DATA_W/8-1:0]           m_axi_wstrb,
  output logic                          m_axi_wlast,
  output logic                          m_axi_wvalid,
  input  logic                          m_axi_wready,
  input  logic [1:0]                    m_axi_bresp,
  input  logic                          m_axi_bvalid,
  output logic                          m_axi_bready,
  output logic                          wr_err_o,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o
);
  localparam int LW = $clog2(FIFO_DEPTH) + 1;
  localparam int EW = ADDR_W + DATA_W;
  state_t state, state_nxt;
  logic accept, pop, full, empty, load, more;
  logic [EW-1:0] push_din, head, head_nxt, src;
  assign accept = bmem_wr_en & ~full & ~bmem_resp;
  assign push_din = {bmem_wr_addr & ~ADDR_W'(7), bmem_wr_data};
  assign pop = (state == WAIT_B) & m_axi_bvalid;
  assign m_axi_bready = state == WAIT_B;
  assign more = fifo_level_o > LW'(1);
  assign m_axi_awlen = '0;
  assign m_axi_awsize = AXI_SIZE_8B;
  assign m_axi_awburst = AXI_BURST_INCR;
  assign m_axi_wstrb = '1;
  assign m_axi_wlast = 1'b1;
  usb_wr_fifo #(.DEPTH(FIFO_DEPTH), .W(EW)) u_fifo (
    .clk(axi_clk),
    .rst(rst),
    .push(accept),
    .pop(pop),
    .din(push_din),
    .dout(head),
    .dout_nxt(head_nxt),
    .full(full),
    .empty(empty),
    .level(fifo_level_o)
  );
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = empty ? IDLE : SEND;
      SEND:    state_nxt = ((~m_axi_awvalid | m_axi_awready) & (~m_axi_wvalid | m_axi_wready)) ? WAIT_B : SEND;
      WAIT_B:  state_nxt = ~m_axi_bvalid ? WAIT_B : (more | accept) ? SEND : IDLE;
      default: state_nxt = IDLE;
    endcase
  end
  // Going straight from WAIT_B to SEND the new head is the entry behind the one being popped,
  // or the request being pushed this very cycle when nothing else is buffered.
  assign load = (state_nxt == SEND) & (state != SEND);
  assign src = (state == WAIT_B) ? (more ? head_nxt : push_din) : head;
  always_ff @(posedge axi_clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      bmem_resp <= 1'b0;
      m_axi_awvalid <= 1'b0;
      m_axi_wvalid <= 1'b0;
      m_axi_awaddr <= '0;
      m_axi_wdata <= '0;
      wr_err_o <= 1'b0;
    end else begin
      state <= state_nxt;
      bmem_resp <= accept;
      m_axi_awvalid <= load | (m_axi_awvalid & ~m_axi_awready);
      m_axi_wvalid <= load | (m_axi_wvalid & ~m_axi_wready);
      if (load) {m_axi_awaddr, m_axi_wdata} <= src;
      if (pop && m_axi_bresp != AXI_RESP_OKAY) wr_err_o <= 1'b1;
    end
endmodule

// File: tb/tb_usb_axi_wr_bridge.sv
// tb_usb_axi_wr_bridge: directed and randomized checks of the write bridge against a transaction-level model
module tb_usb_axi_wr_bridge;
  localparam int DEPTH = 4;
  typedef struct packed {logic [31:0] a; logic [63:0] d;} ent_t;
  logic axi_clk, rst, bmem_wr_en, bmem_resp;
  logic [31:0] bmem_wr_addr, m_axi_awaddr;
  logic [63:0] bmem_wr_data, m_axi_wdata;
  logic [7:0] m_axi_awlen, m_axi_wstrb;
  logic [2:0] m_axi_awsize;
  logic [1:0] m_axi_awburst, m_axi_bresp;
  logic m_axi_awvalid, m_axi_awready, m_axi_wlast, m_axi_wvalid, m_axi_wready;
  logic m_axi_bvalid, m_axi_bready, wr_err_o;
  logic [2:0] fifo_level_o;
  int n_chk, n_fail;
  int aw_dly, w_dly, b_dly, aw_cnt, w_cnt, b_cnt, resp_cnt, aw_hi, w_hi, r0, lvl0;
  bit aw_block, rnd, err_once;
  bit active, awd, wd, mresp, merr, exp_aw, exp_w, exp_b, acc, aw_hs, w_hs, b_hs;
  ent_t q[$];

  usb_axi_wr_bridge #(.FIFO_DEPTH(DEPTH), .ADDR_W(32), .DATA_W(64)) dut (
    .axi_clk(axi_clk), .rst(rst),
    .bmem_wr_en(bmem_wr_en), .bmem_wr_addr(bmem_wr_addr), .bmem_wr_data(bmem_wr_data), .bmem_resp(bmem_resp),
    .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen), .m_axi_awsize(m_axi_awsize),
    .m_axi_awburst(m_axi_awburst), .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
    .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
    .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
    .wr_err_o(wr_err_o), .fifo_level_o(fifo_level_o)
  );

  initial begin
    axi_clk = 1'b0;
    forever #5 axi_clk = ~axi_clk;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Model: queue of accepted entries; a write is in flight once the queue was non-empty
  // while idle, and finishes on the B handshake. The AXI slave is driven from here too.
  always @(negedge axi_clk) begin
    if (rst) begin
      q.delete();
      active = 0; awd = 0; wd = 0; mresp = 0; merr = 0;
      aw_cnt = 0; w_cnt = 0; b_cnt = 0;
      m_axi_awready = 1'b0; m_axi_wready = 1'b0; m_axi_bvalid = 1'b0; m_axi_bresp = 2'b00;
    end else begin
      exp_aw = active && !awd;
      exp_w = active && !wd;
      exp_b = active && awd && wd;
      chk("bmem_resp", 64'(bmem_resp), 64'(mresp));
      chk("level", 64'(fifo_level_o), 64'(q.size()));
      chk("awvalid", 64'(m_axi_awvalid), 64'(exp_aw));
      chk("wvalid", 64'(m_axi_wvalid), 64'(exp_w));
      chk("bready", 64'(m_axi_bready), 64'(exp_b));
      chk("wr_err", 64'(wr_err_o), 64'(merr));
      chk("aw_const", 64'({m_axi_awlen, m_axi_awsize, m_axi_awburst}), 64'({8'd0, 3'b011, 2'b01}));
      chk("w_const", 64'({m_axi_wstrb, m_axi_wlast}), 64'({8'hFF, 1'b1}));
      if (exp_aw) chk("awaddr", 64'(m_axi_awaddr), 64'(q[0].a));
      if (exp_w) chk("wdata", m_axi_wdata, q[0].d);
      resp_cnt += int'(bmem_resp);
      aw_hi += int'(m_axi_awvalid);
      w_hi += int'(m_axi_wvalid);
      m_axi_awready = m_axi_awvalid && !aw_block && (rnd ? $urandom_range(0, 2) != 0 : aw_cnt >= aw_dly);
      aw_cnt = (m_axi_awvalid && !m_axi_awready) ? aw_cnt + 1 : 0;
      m_axi_wready = m_axi_wvalid && (rnd ? $urandom_range(0, 2) != 0 : w_cnt >= w_dly);
      w_cnt = (m_axi_wvalid && !m_axi_wready) ? w_cnt + 1 : 0;
      m_axi_bvalid = exp_b && (rnd ? $urandom_range(0, 1) == 1 : b_cnt >= b_dly);
      m_axi_bresp = (m_axi_bvalid && err_once) ? 2'b10 : 2'b00;
      b_cnt = (exp_b && !m_axi_bvalid) ? b_cnt + 1 : 0;
      lvl0 = q.size();
      acc = bmem_wr_en && lvl0 < DEPTH && !mresp;
      aw_hs = exp_aw && m_axi_awready;
      w_hs = exp_w && m_axi_wready;
      b_hs = exp_b && m_axi_bvalid;
      if (acc) q.push_back('{a: {bmem_wr_addr[31:3], 3'b000}, d: bmem_wr_data});
      if (b_hs) begin
        merr = merr | (m_axi_bresp != 2'b00);
        if (m_axi_bresp != 2'b00) err_once = 0;
        void'(q.pop_front());
        awd = 0; wd = 0;
        active = q.size() > 0;
      end else begin
        awd = awd | aw_hs;
        wd = wd | w_hs;
        if (!active && lvl0 > 0) active = 1;
      end
      mresp = acc;
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge axi_clk);
    #2;
  endtask

  task automatic wait_resp();
    int i = 0;
    do begin
      cyc(1);
      i++;
    end while (!bmem_resp && i < 300);
    chk("resp_timeout", 64'(bmem_resp), 64'd1);
    bmem_wr_en = 1'b0;
  endtask

  task automatic write(input logic [31:0] a, input logic [63:0] d);
    bmem_wr_en = 1'b1;
    bmem_wr_addr = a;
    bmem_wr_data = d;
    wait_resp();
  endtask

  task automatic drain();
    for (int i = 0; i < 500 && (q.size() != 0 || active); i++) cyc(1);
    chk("drain_level", 64'(fifo_level_o), 64'd0);
  endtask

  initial begin
    n_chk = 0; n_fail = 0; resp_cnt = 0; aw_hi = 0; w_hi = 0;
    rst = 1'b1; bmem_wr_en = 1'b0; bmem_wr_addr = '0; bmem_wr_data = '0;
    aw_dly = 0; w_dly = 0; b_dly = 2; aw_block = 0; rnd = 0; err_once = 0;
    cyc(2);
    chk("rst_awvalid", 64'(m_axi_awvalid), 64'd0);
    chk("rst_wvalid", 64'(m_axi_wvalid), 64'd0);
    chk("rst_bready", 64'(m_axi_bready), 64'd0);
    chk("rst_resp", 64'(bmem_resp), 64'd0);
    chk("rst_level", 64'(fifo_level_o), 64'd0);
    chk("rst_awaddr", 64'(m_axi_awaddr), 64'd0);
    chk("rst_wdata", m_axi_wdata, 64'd0);
    chk("rst_err", 64'(wr_err_o), 64'd0);
    rst = 1'b0;
    cyc(1);
    // single aligned write
    write(32'h1000_0007, 64'hDEAD_BEEF_0123_4567);
    cyc(1);
    chk("resp_one_cycle", 64'(bmem_resp), 64'd0);
    chk("single_awvalid", 64'(m_axi_awvalid), 64'd1);
    chk("single_awaddr", 64'(m_axi_awaddr), 64'h1000_0000);
    chk("single_wdata", m_axi_wdata, 64'hDEAD_BEEF_0123_4567);
    drain();
    // late awready, immediate wready
    aw_dly = 5; aw_hi = 0; w_hi = 0;
    write($urandom, {$urandom, $urandom});
    drain();
    chk("aw_hold_cycles", 64'(aw_hi), 64'd6);
    chk("w_hold_cycles", 64'(w_hi), 64'd1);
    aw_dly = 0;
    // AW blocked: FIFO fills, fifth request stalls
    aw_block = 1; r0 = resp_cnt;
    for (int i = 0; i < 4; i++) write($urandom, {$urandom, $urandom});
    bmem_wr_en = 1'b1; bmem_wr_addr = $urandom; bmem_wr_data = {$urandom, $urandom};
    cyc(10);
    chk("full_resp_count", 64'(resp_cnt - r0), 64'd4);
    chk("full_level", 64'(fifo_level_o), 64'd4);
    chk("full_stall_resp", 64'(bmem_resp), 64'd0);
    aw_block = 0;
    wait_resp();
    drain();
    // random traffic
    rnd = 1;
    repeat (40) begin
      write($urandom, {$urandom, $urandom});
      cyc(int'($urandom_range(0, 3)));
    end
    drain();
    rnd = 0;
    chk("rand_no_err", 64'(wr_err_o), 64'd0);
    // SLVERR is sticky
    err_once = 1;
    write($urandom, {$urandom, $urandom});
    drain();
    chk("err_set", 64'(wr_err_o), 64'd1);
    repeat (2) write($urandom, {$urandom, $urandom});
    drain();
    chk("err_sticky", 64'(wr_err_o), 64'd1);
    // reset while waiting for B with three entries buffered
    b_dly = 100;
    repeat (3) write($urandom, {$urandom, $urandom});
    cyc(3);
    chk("pre_rst_bready", 64'(m_axi_bready), 64'd1);
    chk("pre_rst_level", 64'(fifo_level_o), 64'd3);
    rst = 1'b1;
    #1;
    chk("async_awvalid", 64'(m_axi_awvalid), 64'd0);
    chk("async_wvalid", 64'(m_axi_wvalid), 64'd0);
    chk("async_bready", 64'(m_axi_bready), 64'd0);
    chk("async_level", 64'(fifo_level_o), 64'd0);
    chk("async_err", 64'(wr_err_o), 64'd0);
    cyc(2);
    rst = 1'b0;
    b_dly = 2;
    cyc(3);
    chk("post_rst_idle", 64'(m_axi_awvalid), 64'd0);
    write(32'h1000_0007, 64'hDEAD_BEEF_0123_4567);
    cyc(1);
    chk("post_rst_awaddr", 64'(m_axi_awaddr), 64'h1000_0000);
    chk("post_rst_wdata", m_axi_wdata, 64'hDEAD_BEEF_0123_4567);
    drain();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
